// File: rtl/psram_qspi_frontend.sv
// QSPI PSRAM target front end: decodes quad read (0xEB) and quad write (0x38)
// transactions from an oversampled sck and turns them into word-wide store accesses.
module psram_qspi_frontend (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce_n,
    input  logic        sck,
    input  logic [3:0]  dio_i,
    output logic [3:0]  dio_o,
    output logic        dio_oe,
    output logic        sel,
    output logic        write,
    output logic [23:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  wmask,
    input  logic [31:0] rdata,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;

    state_t      state_q, state_d;
    logic        sck_q, sck_d;
    logic        armed_q, armed_d;
    logic        rd_q, rd_d;
    logic        half_q, half_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  nib_q, nib_d;
    logic [1:0]  bc_q, bc_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [23:0] cur_addr_q, cur_addr_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic [3:0]  dio_o_q, dio_o_d;
    logic        dio_oe_q, dio_oe_d;
    logic        sel_q, sel_d;
    logic        write_q, write_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;

    logic        rise, fall;
    logic [7:0]  rbyte;
    logic [3:0]  fmask;

    assign rise = sck & ~sck_q;
    assign fall = ~sck & sck_q;

    always_comb begin
        state_d    = state_q;
        sck_d      = sck;
        // A transaction may only start after ce_n has been seen high since reset.
        armed_d    = armed_q | ce_n;
        rd_d       = rd_q;
        half_d     = half_q;
        cnt_d      = cnt_q;
        nib_d      = nib_q;
        bc_d       = bc_q;
        cmd_d      = cmd_q;
        cur_addr_d = cur_addr_q;
        rbuf_d     = (sel_q && !write_q) ? rdata : rbuf_q;
        wbuf_d     = wbuf_q;
        dio_o_d    = dio_o_q;
        dio_oe_d   = dio_oe_q;
        sel_d      = 1'b0;
        write_d    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = 32'h0;
        wmask_d    = 4'h0;
        rbyte      = rbuf_q[{nib_q[2:1], 3'b000} +: 8];
        fmask      = (bc_q == 2'd1) ? 4'b0001 : (bc_q == 2'd2) ? 4'b0011 : 4'b0111;

        if (state_q != IDLE && ce_n) begin
            state_d  = IDLE;
            dio_o_d  = 4'h0;
            dio_oe_d = 1'b0;
            // Flush whole bytes of a short write; a dangling high nibble is dropped.
            if (state_q == WDATA && bc_q != 2'd0) begin
                sel_d   = 1'b1;
                write_d = 1'b1;
                addr_d  = cur_addr_q;
                wmask_d = fmask;
                wdata_d = wbuf_q & {{8{fmask[3]}}, {8{fmask[2]}}, {8{fmask[1]}}, {8{fmask[0]}}};
            end
        end else begin
            case (state_q)
                IDLE: begin
                    dio_o_d  = 4'h0;
                    dio_oe_d = 1'b0;
                    if (!ce_n && armed_q) begin
                        state_d = CMD;
                        armed_d = 1'b0;
                        cnt_d   = 3'd0;
                        nib_d   = 3'd0;
                        bc_d    = 2'd0;
                        half_d  = 1'b0;
                        wbuf_d  = 32'h0;
                    end
                end
                CMD: if (rise) begin
                    cmd_d = {cmd_q[6:0], dio_i[0]};
                    if (cnt_q == 3'd7) begin
                        cnt_d = 3'd0;
                        if (cmd_d == 8'hEB) begin
                            state_d = ADDR;
                            rd_d    = 1'b1;
                        end else if (cmd_d == 8'h38) begin
                            state_d = ADDR;
                            rd_d    = 1'b0;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ADDR: if (rise) begin
                    cur_addr_d = {cur_addr_q[19:0], dio_i};
                    if (cnt_q == 3'd5) begin
                        cnt_d = 3'd0;
                        if (rd_q) begin
                            sel_d   = 1'b1;
                            addr_d  = cur_addr_d;
                            state_d = DUMMY;
                        end else begin
                            state_d = WDATA;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                DUMMY: if (rise) begin
                    if (cnt_q == 3'd5) begin
                        cnt_d   = 3'd0;
                        nib_d   = 3'd0;
                        state_d = RDATA;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                RDATA: if (fall) begin
                    dio_o_d  = nib_q[0] ? rbyte[3:0] : rbyte[7:4];
                    dio_oe_d = 1'b1;
                    nib_d    = nib_q + 3'd1;
                    // Prefetch the next word while the host clocks out the last nibble.
                    if (nib_q == 3'd7) begin
                        cur_addr_d = cur_addr_q + 24'd4;
                        sel_d      = 1'b1;
                        addr_d     = cur_addr_q + 24'd4;
                    end
                end
                WDATA: if (rise) begin
                    if (!half_q) begin
                        wbuf_d[{bc_q, 3'b100} +: 4] = dio_i;
                        half_d = 1'b1;
                    end else begin
                        wbuf_d[{bc_q, 3'b000} +: 4] = dio_i;
                        half_d = 1'b0;
                        if (bc_q == 2'd3) begin
                            sel_d      = 1'b1;
                            write_d    = 1'b1;
                            addr_d     = cur_addr_q;
                            wdata_d    = wbuf_d;
                            wmask_d    = 4'hF;
                            cur_addr_d = cur_addr_q + 24'd4;
                            bc_d       = 2'd0;
                            wbuf_d     = 32'h0;
                        end else begin
                            bc_d = bc_q + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            sck_q      <= 1'b0;
            armed_q    <= 1'b0;
            rd_q       <= 1'b0;
            half_q     <= 1'b0;
            cnt_q      <= 3'd0;
            nib_q      <= 3'd0;
            bc_q       <= 2'd0;
            cmd_q      <= 8'h0;
            cur_addr_q <= 24'h0;
            rbuf_q     <= 32'h0;
            wbuf_q     <= 32'h0;
            dio_o_q    <= 4'h0;
            dio_oe_q   <= 1'b0;
            sel_q      <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= 24'h0;
            wdata_q    <= 32'h0;
            wmask_q    <= 4'h0;
        end else begin
            state_q    <= state_d;
            sck_q      <= sck_d;
            armed_q    <= armed_d;
            rd_q       <= rd_d;
            half_q     <= half_d;
            cnt_q      <= cnt_d;
            nib_q      <= nib_d;
            bc_q       <= bc_d;
            cmd_q      <= cmd_d;
            cur_addr_q <= cur_addr_d;
            rbuf_q     <= rbuf_d;
            wbuf_q     <= wbuf_d;
            dio_o_q    <= dio_o_d;
            dio_oe_q   <= dio_oe_d;
            sel_q      <= sel_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
        end
    end

    assign dio_o     = dio_o_q;
    assign dio_oe    = dio_oe_q;
    assign sel       = sel_q;
    assign write     = write_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign wmask     = wmask_q;
    assign state_dbg = state_q;

endmodule
